alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
// Registered execute stage directly downstream of the 8-entry register file.
// - Consumes SR1/SR2 read data plus the current IR; executes LC-3 ADD/AND/NOT.
// - Holds the result in a one-deep valid/ready pipeline register.
// - Drives the write-back strobe, DR address and data back into the register file.
// - Maintains the NZP condition-code register and the BEN branch-enable term.
// PARAMETERS
// WIDTH      16  datapath width (IR, SR1, SR2, Result)
// CNT_WIDTH  16  width of the retired-instruction counter
// PORTS
// Clk          in   1          system clock, all state on posedge
// Reset        in   1          asynchronous, active-high reset
// in_valid     in   1          IR/SR1/SR2 carry a valid instruction
// in_ready     out  1          stage can accept this cycle
// IR           in   WIDTH      instruction word
// SR1          in   WIDTH      register-file read port 1 (base reg IR[8:6])
// SR2          in   WIDTH      register-file read port 2 (IR[2:0])
// out_valid    out  1          Result/DR hold a completed instruction
// out_ready    in   1          write-back side accepts this cycle
// Ld_REG       out  1          register-file write strobe
// DR           out  3          destination register (registered IR[11:9])
// Result       out  WIDTH      write-back data, to register-file In
// NZP          out  3          condition codes {N,Z,P}
// BEN          out  1          branch enable for the IR currently at the input
// retired      out  CNT_WIDTH  count of instructions leaving the stage
// BEHAVIOUR
// Reset (async, immediate, while asserted):
// - out_valid=0, Ld_REG=0, DR=0, Result=0, NZP=3'b010, retired=0.
// - in_ready=1 once the pipe register is empty.
// Handshake:
// - in_ready = !out_valid | out_ready (combinational).
// - accept = in_valid & in_ready; fire = out_valid & out_ready.
// - Latency: an instruction accepted at edge k is presented with out_valid=1 after edge k.
// - Throughput: 1 instruction/cycle while out_ready=1.
// - out_valid is set on accept, cleared on fire with no accept; fire+accept in one cycle keeps out_valid=1.
// - Result, DR and the write enable are stable while out_valid & !out_ready.
// Execute, on IR[15:12]; operand B = IR[5] ? sext(IR[4:0]) : SR2:
// - 4'b0001 ADD: SR1 + B, modulo 2^WIDTH; overflow is discarded. Write enable = 1.
// - 4'b0101 AND: SR1 & B. Write enable = 1.
// - 4'b1001 NOT: ~SR1; IR[5:0] ignored. Write enable = 1.
// - Any other opcode: accepted and retired; Result = SR1; write enable = 0.
// Write-back and condition codes:
// - Ld_REG = fire & write enable, so the write takes effect on the same edge as fire.
// - NZP updates only on a fire with write enable = 1.
// - NZP = Result[WIDTH-1] ? 100 : (Result==0 ? 010 : 001). Non-writing ops leave NZP unchanged.
// BEN = |(IR[11:9] & NZP), combinational from the committed NZP (pre-update in a fire cycle).
// retired increments on every fire and wraps at 2^CNT_WIDTH.
// No hazard forwarding: a dependent instruction must not be presented until its producer has fired.
// Reset mid-stall: the held instruction is discarded; Ld_REG never pulses for it.
// TESTING
// Reset, then ADD R1,R2,#-1 (IR=16'h12BF), SR1=16'h0005, out_ready=1:
//   -> next cycle out_valid=1, Result=0004, DR=1, Ld_REG=1; then NZP=001, retired=1.
// AND register mode (IR=16'h5442), SR1=16'hF0F0, SR2=16'h0F0F -> Result=0000, NZP becomes 010.
// ADD overflow, SR1=16'h7FFF, imm +1 -> Result=16'h8000, NZP=100.
// NOT, SR1=16'h0000 -> Result=16'hFFFF, NZP=100.
// Back-pressure:
//   ADD accepted, out_ready=0 for 3 cycles -> in_ready=0, Result and DR held, Ld_REG=0.
//   Then out_ready=1 -> a single Ld_REG pulse, and a new accept in the same cycle.
// Non-ALU opcode (IR=16'h0E02, BRnzp) with NZP=001 -> BEN=1; on fire Ld_REG=0, NZP unchanged, retired+1.
// Reset asserted while out_valid=1 and out_ready=0 -> outputs clear immediately, no write-back pulse.
// Streaming: 4 back-to-back ADDs with out_ready=1 -> 4 consecutive Ld_REG pulses, retired=4.

Source files
------------

// File: rtl/alu_exec_stage.sv
// LC-3 execute stage: ADD/AND/NOT into a one-deep valid/ready register.
// Write-back strobe, NZP condition codes, BEN and a retired-instruction counter.
module alu_exec_stage #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     IR,
  input  logic [WIDTH-1:0]     SR1,
  input  logic [WIDTH-1:0]     SR2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 Ld_REG,
  output logic [2:0]           DR,
  output logic [WIDTH-1:0]     Result,
  output logic [2:0]           NZP,
  output logic                 BEN,
  output logic [CNT_WIDTH-1:0] retired
);

  logic             accept;
  logic             fire;
  logic             we_q;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_we;
  logic [2:0]       nzp_next;

  // Base register select IR[8:6] is resolved by the register file, not here.
  logic unused_ir;
  assign unused_ir = ^IR[8:6];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid && out_ready;
  assign Ld_REG   = fire && we_q;
  assign BEN      = |(IR[11:9] & NZP);

  always_comb begin
    op_b    = IR[5] ? {{(WIDTH-5){IR[4]}}, IR[4:0]} : SR2;
    alu_res = SR1;
    alu_we  = 1'b0;
    case (IR[15:12])
      4'b0001: begin alu_res = SR1 + op_b; alu_we = 1'b1; end
      4'b0101: begin alu_res = SR1 & op_b; alu_we = 1'b1; end
      4'b1001: begin alu_res = ~SR1;       alu_we = 1'b1; end
      default: begin alu_res = SR1;        alu_we = 1'b0; end
    endcase
  end

  // Condition codes derive from the result being written back, not the incoming one.
  always_comb begin
    if (Result[WIDTH-1])      nzp_next = 3'b100;
    else if (Result == '0)    nzp_next = 3'b010;
    else                      nzp_next = 3'b001;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_valid <= 1'b0;
      we_q      <= 1'b0;
      DR        <= 3'd0;
      Result    <= '0;
      NZP       <= 3'b010;
      retired   <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        we_q      <= alu_we;
        DR        <= IR[11:9];
        Result    <= alu_res;
      end else if (fire) begin
        out_valid <= 1'b0;
      end
      if (fire) begin
        retired <= retired + CNT_WIDTH'(1);
        if (we_q) NZP <= nzp_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with hand-computed expectations.
module tb_alu_exec_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] IR;
  logic [15:0] SR1;
  logic [15:0] SR2;
  logic        out_valid;
  logic        out_ready;
  logic        Ld_REG;
  logic [2:0]  DR;
  logic [15:0] Result;
  logic [2:0]  NZP;
  logic        BEN;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  alu_exec_stage #(.WIDTH(16), .CNT_WIDTH(16)) dut (
    .Clk(Clk), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .IR(IR), .SR1(SR1), .SR2(SR2),
    .out_valid(out_valid), .out_ready(out_ready),
    .Ld_REG(Ld_REG), .DR(DR), .Result(Result),
    .NZP(NZP), .BEN(BEN), .retired(retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    IR = 16'h0000; SR1 = 16'h0000; SR2 = 16'h0000;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_result",    Result, 16'h0000);
    check("rst_dr",        DR, 0);
    check("rst_nzp",       NZP, 3'b010);
    check("rst_retired",   retired, 0);
    check("rst_in_ready",  in_ready, 1);
    check("rst_ld_reg",    Ld_REG, 0);
    step(); step();
    Reset = 1'b0;

    // ADD R1,R2,#-1
    IR = 16'h12BF; SR1 = 16'h0005; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    check("add_out_valid", out_valid, 1);
    check("add_result",    Result, 16'h0004);
    check("add_dr",        DR, 1);
    check("add_ld_reg",    Ld_REG, 1);
    step();
    check("add_nzp",       NZP, 3'b001);
    check("add_retired",   retired, 1);
    check("add_drained",   out_valid, 0);

    // AND R2,R1,R2 register mode
    IR = 16'h5442; SR1 = 16'hF0F0; SR2 = 16'h0F0F; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    check("and_result",    Result, 16'h0000);
    check("and_dr",        DR, 2);
    check("and_ld_reg",    Ld_REG, 1);
    step();
    check("and_nzp",       NZP, 3'b010);
    check("and_retired",   retired, 2);

    // ADD R3,R3,#1 overflow
    IR = 16'h16E1; SR1 = 16'h7FFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    check("ovf_result",    Result, 16'h8000);
    check("ovf_dr",        DR, 3);
    step();
    check("ovf_nzp",       NZP, 3'b100);
    check("ovf_retired",   retired, 3);

    // NOT R4,R5
    IR = 16'h997F; SR1 = 16'h0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    check("not_result",    Result, 16'hFFFF);
    check("not_dr",        DR, 4);
    step();
    check("not_nzp",       NZP, 3'b100);
    check("not_retired",   retired, 4);

    // Back-pressure: ADD held for 3 cycles, next AND waits at the input
    out_ready = 1'b0;
    IR = 16'h12BF; SR1 = 16'h0010; in_valid = 1'b1;
    step();
    IR = 16'h5442; SR1 = 16'hFFFF; SR2 = 16'h00FF;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_result",   Result, 16'h000F);
      check("bp_dr",       DR, 1);
      check("bp_ld_reg",   Ld_REG, 0);
      check("bp_in_ready", in_ready, 0);
      check("bp_retired",  retired, 4);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ld",    Ld_REG, 1);
    check("bp_release_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    #1;
    check("bp_next_result",  Result, 16'h00FF);
    check("bp_next_dr",      DR, 2);
    check("bp_next_valid",   out_valid, 1);
    check("bp_next_retired", retired, 5);
    check("bp_next_nzp",     NZP, 3'b001);
    step();
    check("bp_end_retired",  retired, 6);
    check("bp_end_valid",    out_valid, 0);

    // Non-ALU opcode: BEN, no write, NZP untouched
    IR = 16'h0802; SR1 = 16'h0000; in_valid = 1'b0;
    #1;
    check("ben_n_only", BEN, 0);
    IR = 16'h0E02; in_valid = 1'b1;
    #1;
    check("ben_nzp", BEN, 1);
    step();
    in_valid = 1'b0;
    #1;
    check("br_valid",   out_valid, 1);
    check("br_ld_reg",  Ld_REG, 0);
    check("br_result",  Result, 16'h0000);
    step();
    check("br_nzp",     NZP, 3'b001);
    check("br_retired", retired, 7);

    // Reset while an instruction is stalled
    out_ready = 1'b0;
    IR = 16'h12BF; SR1 = 16'h0005; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("stall_valid", out_valid, 1);
    Reset = 1'b1;
    #1;
    check("mid_rst_valid",   out_valid, 0);
    check("mid_rst_ld_reg",  Ld_REG, 0);
    check("mid_rst_result",  Result, 16'h0000);
    check("mid_rst_nzp",     NZP, 3'b010);
    check("mid_rst_retired", retired, 0);
    out_ready = 1'b1;
    #1;
    check("mid_rst_ld_ready", Ld_REG, 0);
    step();
    Reset = 1'b0;
    #1;
    check("post_rst_valid", out_valid, 0);

    // Streaming: 4 back-to-back ADDs
    IR = 16'h12BF; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      SR1 = 16'(i + 1);
      step();
      check("stream_result",  Result, 32'(i));
      check("stream_ld_reg",  Ld_REG, 1);
      check("stream_retired", retired, 32'(i));
    end
    in_valid = 1'b0;
    step();
    check("stream_retired_end", retired, 4);
    check("stream_valid_end",   out_valid, 0);
    check("stream_nzp_end",     NZP, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
